// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul scheduler: FSM states, APB
// address regions and status register layout.
package matmul_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_FEED  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      RGN_CTRL    = 2'd0,
      RGN_OP_A    = 2'd1,
      RGN_OP_B    = 2'd2,
      RGN_ILLEGAL = 2'd3
   } region_e;

   localparam int unsigned RGN_LSB       = 6;
   localparam int unsigned IDX_LSB       = 2;
   localparam int unsigned IDX_W         = 4;
   localparam int unsigned START_BIT     = 0;
   localparam int unsigned STAT_BUSY_BIT = 0;
   localparam int unsigned STAT_DONE_BIT = 1;

endpackage

// File: rtl/matmul_apb_if.sv
// APB slave front end: region decode, error response, operand-register
// access and the single wait state for operand reads.
module matmul_apb_if
   import matmul_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BUS_WIDTH  = 64,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic                  pwrite_i,
   input  logic [ADDR_WIDTH-1:0] paddr_i,
   input  logic [BUS_WIDTH-1:0]  pwdata_i,
   output logic [BUS_WIDTH-1:0]  prdata_o,
   output logic                  pready_o,
   output logic                  pslverr_o,
   output logic [ADDR_WIDTH-1:0] op_addr_o,
   output logic [DATA_WIDTH-1:0] op_wdata_o,
   output logic                  op_we_a_o,
   output logic                  op_we_b_o,
   input  logic [DATA_WIDTH-1:0] op_rdata_a_i,
   input  logic [DATA_WIDTH-1:0] op_rdata_b_i,
   input  logic                  busy_i,
   input  logic                  done_i,
   input  logic                  feed_i,
   input  logic [ADDR_WIDTH-1:0] seq_addr_i,
   output logic                  start_o
);

   region_e          region;
   logic [IDX_W-1:0] idx;
   logic             access;
   logic             is_op;
   logic             wr_start;
   logic             err;
   logic             first_rd;
   logic             wait_d, wait_q;
   logic [BUS_WIDTH-1:0] status;
   logic             unused_bits;

   assign region   = region_e'(paddr_i[RGN_LSB+1:RGN_LSB]);
   assign idx      = paddr_i[IDX_LSB+IDX_W-1:IDX_LSB];
   assign access   = psel_i & penable_i;
   assign is_op    = (region == RGN_OP_A) || (region == RGN_OP_B);
   assign wr_start = pwrite_i && (region == RGN_CTRL) && pwdata_i[START_BIT];
   assign err      = access && ((region == RGN_ILLEGAL) ||
                                (pwrite_i && busy_i && (is_op || wr_start)));
   assign first_rd = access && !pwrite_i && is_op && !wait_q;
   assign wait_d   = first_rd;

   assign unused_bits = ^{paddr_i[ADDR_WIDTH-1:RGN_LSB+2], paddr_i[IDX_LSB-1:0], pwdata_i};

   // NOTE: every output gets a default before any branch, so no latch is inferred.
   always_comb begin
      status                = '0;
      status[STAT_BUSY_BIT] = busy_i;
      status[STAT_DONE_BIT] = done_i;

      prdata_o   = '0;
      pready_o   = 1'b0;
      pslverr_o  = 1'b0;
      op_addr_o  = '0;
      op_wdata_o = '0;
      op_we_a_o  = 1'b0;
      op_we_b_o  = 1'b0;
      start_o    = 1'b0;

      // NOTE: outputs are gated by rst_ni so they drop to 0 the moment reset asserts,
      // even while the master keeps an access open.
      if (rst_ni) begin
         op_wdata_o = DATA_WIDTH'(pwdata_i);
         if (feed_i) op_addr_o = seq_addr_i;
         if (access) begin
            pready_o  = !first_rd;
            pslverr_o = err;
            if (!err) begin
               // An APB operand access owns the address only in its first data cycle.
               if (is_op && (pwrite_i || !wait_q)) op_addr_o = ADDR_WIDTH'(idx);
               if (pwrite_i) begin
                  op_we_a_o = (region == RGN_OP_A);
                  op_we_b_o = (region == RGN_OP_B);
                  start_o   = wr_start;
               end else if (region == RGN_CTRL) begin
                  prdata_o = status;
               end else if (wait_q) begin
                  prdata_o = (region == RGN_OP_A) ? BUS_WIDTH'(op_rdata_a_i)
                                                  : BUS_WIDTH'(op_rdata_b_i);
               end
            end
         end
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) wait_q <= 1'b0;
      else         wait_q <= wait_d;
   end

endmodule

// File: rtl/matmul_sched.sv
// Systolic-array scheduler: start/clear/feed/done sequencing with an
// APB control and operand-access front end.
module matmul_sched
   import matmul_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BUS_WIDTH  = 64,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MAX_DIM    = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          psel_i,
   input  logic                          penable_i,
   input  logic                          pwrite_i,
   input  logic [ADDR_WIDTH-1:0]         paddr_i,
   input  logic [BUS_WIDTH-1:0]          pwdata_i,
   output logic [BUS_WIDTH-1:0]          prdata_o,
   output logic                          pready_o,
   output logic                          pslverr_o,
   output logic [ADDR_WIDTH-1:0]         op_addr_o,
   output logic [DATA_WIDTH-1:0]         op_wdata_o,
   output logic                          op_we_a_o,
   output logic                          op_we_b_o,
   input  logic [DATA_WIDTH-1:0]         op_rdata_a_i,
   input  logic [DATA_WIDTH-1:0]         op_rdata_b_i,
   output logic                          sa_clear_o,
   output logic                          sa_step_o,
   output logic [$clog2(3*MAX_DIM)-1:0]  sa_cnt_o,
   output logic                          busy_o
);

   localparam int unsigned CNT_W       = $clog2(3*MAX_DIM);
   localparam int unsigned MATRIX_SIZE = MAX_DIM * MAX_DIM;
   localparam logic [CNT_W-1:0] FEED_LAST = CNT_W'(3*MAX_DIM - 3);

   state_e           state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             done_d, done_q;
   logic             clear_d, clear_q;
   logic             step_d, step_q;
   logic             busy_d, busy_q;
   logic             start;
   logic [ADDR_WIDTH-1:0] seq_addr;

   assign seq_addr = ADDR_WIDTH'(32'(cnt_q) % 32'(MATRIX_SIZE));

   matmul_apb_if #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUS_WIDTH  (BUS_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_apb_if (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .psel_i       (psel_i),
      .penable_i    (penable_i),
      .pwrite_i     (pwrite_i),
      .paddr_i      (paddr_i),
      .pwdata_i     (pwdata_i),
      .prdata_o     (prdata_o),
      .pready_o     (pready_o),
      .pslverr_o    (pslverr_o),
      .op_addr_o    (op_addr_o),
      .op_wdata_o   (op_wdata_o),
      .op_we_a_o    (op_we_a_o),
      .op_we_b_o    (op_we_b_o),
      .op_rdata_a_i (op_rdata_a_i),
      .op_rdata_b_i (op_rdata_b_i),
      .busy_i       (busy_q),
      .done_i       (done_q),
      .feed_i       (step_q),
      .seq_addr_i   (seq_addr),
      .start_o      (start)
   );

   always_comb begin
      state_d = state_q;
      done_d  = done_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_CLEAR;
         ST_CLEAR: state_d = ST_FEED;
         ST_FEED:  if (cnt_q == FEED_LAST) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they are flops aligned with the state.
      if (state_d == ST_CLEAR) done_d = 1'b0;
      if (state_d == ST_DONE)  done_d = 1'b1;
      cnt_d   = (state_q == ST_FEED && state_d == ST_FEED) ? cnt_q + 1'b1 : '0;
      clear_d = (state_d == ST_CLEAR);
      step_d  = (state_d == ST_FEED);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         clear_q <= 1'b0;
         step_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         clear_q <= clear_d;
         step_q  <= step_d;
         busy_q  <= busy_d;
      end
   end

   assign sa_clear_o = clear_q;
   assign sa_step_o  = step_q;
   assign sa_cnt_o   = cnt_q;
   assign busy_o     = busy_q;

endmodule

// File: tb/tb_matmul_sched.sv
// Self-checking bench for matmul_sched: table-driven APB accesses with a read
// scoreboard, plus hand-written start, busy-error and reset sequences.
module tb_matmul_sched;

   localparam int DW = 32;
   localparam int BW = 64;
   localparam int AW = 32;
   localparam int MD = 4;
   localparam int CW = $clog2(3*MD);

   logic          clk = 1'b0;
   logic          rst_ni;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [BW-1:0] pwdata;
   logic [BW-1:0] prdata_o;
   logic          pready_o, pslverr_o;
   logic [AW-1:0] op_addr_o;
   logic [DW-1:0] op_wdata_o;
   logic          op_we_a_o, op_we_b_o;
   logic [DW-1:0] op_rdata_a, op_rdata_b;
   logic          sa_clear_o, sa_step_o, busy_o;
   logic [CW-1:0] sa_cnt_o;

   int n_checks = 0;
   int n_errs   = 0;
   logic [63:0] sb_q[$];

   always #5 clk = ~clk;

   matmul_sched #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .MAX_DIM(MD)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .psel_i       (psel),
      .penable_i    (penable),
      .pwrite_i     (pwrite),
      .paddr_i      (paddr),
      .pwdata_i     (pwdata),
      .prdata_o     (prdata_o),
      .pready_o     (pready_o),
      .pslverr_o    (pslverr_o),
      .op_addr_o    (op_addr_o),
      .op_wdata_o   (op_wdata_o),
      .op_we_a_o    (op_we_a_o),
      .op_we_b_o    (op_we_b_o),
      .op_rdata_a_i (op_rdata_a),
      .op_rdata_b_i (op_rdata_b),
      .sa_clear_o   (sa_clear_o),
      .sa_step_o    (sa_step_o),
      .sa_cnt_o     (sa_cnt_o),
      .busy_o       (busy_o)
   );

   // Operand register files with registered (1-cycle) read data.
   logic [DW-1:0] mem_a [16];
   logic [DW-1:0] mem_b [16];
   initial begin
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
   end
   always @(posedge clk) begin
      if (op_we_a_o) mem_a[op_addr_o[3:0]] <= op_wdata_o;
      if (op_we_b_o) mem_b[op_addr_o[3:0]] <= op_wdata_o;
      op_rdata_a <= mem_a[op_addr_o[3:0]];
      op_rdata_b <= mem_b[op_addr_o[3:0]];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [63:0] wdata,
                           output logic [63:0] rdata, output logic err, output int waits,
                           output logic we_a, output logic we_b, output logic [31:0] wd);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
      @(posedge clk); #1;
      penable = 1'b1;
      waits = 0;
      @(negedge clk);
      while (!pready_o && waits < 4) begin
         waits++;
         @(negedge clk);
      end
      if (!pready_o) begin
         n_checks++;
         n_errs++;
         $display("FAIL apb_timeout: pready stayed 0 for addr 0x%0h, want 1", addr);
      end
      rdata = prdata_o; err = pslverr_o; we_a = op_we_a_o; we_b = op_we_b_o; wd = op_wdata_o;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
   endtask

   task automatic do_read(input string name, input logic [31:0] addr,
                          input logic [63:0] exp, input int exp_waits);
      logic [63:0] rd; logic er, wa, wb; logic [31:0] wd; int w;
      sb_q.push_back(exp);
      apb_xfer(1'b0, addr, '0, rd, er, w, wa, wb, wd);
      check({name, ".waits"}, 64'(w), 64'(exp_waits));
      check({name, ".err"}, 64'(er), 64'd0);
      check({name, ".data"}, rd, sb_q.pop_front());
   endtask

   task automatic do_write(input string name, input logic [31:0] addr,
                           input logic [63:0] data, input logic exp_err);
      logic [63:0] rd; logic er, wa, wb; logic [31:0] wd; int w;
      apb_xfer(1'b1, addr, data, rd, er, w, wa, wb, wd);
      check({name, ".err"}, 64'(er), 64'(exp_err));
      if (exp_err) check({name, ".we"}, 64'({wa, wb}), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".pready"},  64'(pready_o),   64'd0);
      check({tag, ".pslverr"}, 64'(pslverr_o),  64'd0);
      check({tag, ".busy"},    64'(busy_o),     64'd0);
      check({tag, ".clear"},   64'(sa_clear_o), 64'd0);
      check({tag, ".step"},    64'(sa_step_o),  64'd0);
      check({tag, ".cnt"},     64'(sa_cnt_o),   64'd0);
      check({tag, ".we"},      64'({op_we_a_o, op_we_b_o}), 64'd0);
      check({tag, ".prdata"},  prdata_o,        64'd0);
      check({tag, ".op_addr"}, 64'(op_addr_o),  64'd0);
      check({tag, ".op_wdata"},64'(op_wdata_o), 64'd0);
   endtask

   typedef struct {
      string       name;
      logic        wr;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [63:0] exp_rdata;
      logic        chk_rd;
      logic        exp_err;
      int          exp_waits;
      logic        exp_we_a;
      logic        exp_we_b;
   } vec_t;

   initial begin
      vec_t vecs[11];
      logic [63:0] rd; logic er, wa, wb; logic [31:0] wd; int w;
      int n_clr, n_step, n_busy;
      logic found;

      rst_ni = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      repeat (2) @(posedge clk);
      #1 check_all_zero("reset");
      rst_ni = 1'b1;
      @(posedge clk); #1;

      //          name          wr    addr            wdata                   exp_rdata        chk   err  wt we_a  we_b
      vecs[0]  = '{"wr_a5",      1'b1, 32'h54,         64'h11,                 64'h0,           1'b0, 1'b0, 0, 1'b1, 1'b0};
      vecs[1]  = '{"wr_b0",      1'b1, 32'h80,         64'hCAFE,               64'h0,           1'b0, 1'b0, 0, 1'b0, 1'b1};
      vecs[2]  = '{"wr_a15",     1'b1, 32'h7C,         64'h1234_5678_FFFF_FFFF,64'h0,           1'b0, 1'b0, 0, 1'b1, 1'b0};
      vecs[3]  = '{"rd_a5",      1'b0, 32'h54,         64'h0,                  64'h11,          1'b1, 1'b0, 1, 1'b0, 1'b0};
      vecs[4]  = '{"rd_b0",      1'b0, 32'h80,         64'h0,                  64'hCAFE,        1'b1, 1'b0, 1, 1'b0, 1'b0};
      vecs[5]  = '{"rd_a15_hi",  1'b0, 32'hABCD_017F,  64'h0,                  64'hFFFF_FFFF,   1'b1, 1'b0, 1, 1'b0, 1'b0};
      vecs[6]  = '{"rd_stat0",   1'b0, 32'h00,         64'h0,                  64'h0,           1'b1, 1'b0, 0, 1'b0, 1'b0};
      vecs[7]  = '{"rd_ill",     1'b0, 32'hC0,         64'h0,                  64'h0,           1'b0, 1'b1, 0, 1'b0, 1'b0};
      vecs[8]  = '{"wr_ill",     1'b1, 32'hC0,         64'h77,                 64'h0,           1'b0, 1'b1, 0, 1'b0, 1'b0};
      vecs[9]  = '{"wr_start0",  1'b1, 32'h00,         64'h2,                  64'h0,           1'b0, 1'b0, 0, 1'b0, 1'b0};
      vecs[10] = '{"rd_stat1",   1'b0, 32'h00,         64'h0,                  64'h0,           1'b1, 1'b0, 0, 1'b0, 1'b0};

      foreach (vecs[i]) begin
         if (!vecs[i].wr && vecs[i].chk_rd) sb_q.push_back(vecs[i].exp_rdata);
         apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, w, wa, wb, wd);
         check({vecs[i].name, ".waits"}, 64'(w), 64'(vecs[i].exp_waits));
         check({vecs[i].name, ".err"}, 64'(er), 64'(vecs[i].exp_err));
         check({vecs[i].name, ".we"}, 64'({wa, wb}), 64'({vecs[i].exp_we_a, vecs[i].exp_we_b}));
         if (vecs[i].wr && !vecs[i].exp_err)
            check({vecs[i].name, ".wdata"}, 64'(wd), 64'(vecs[i].wdata[31:0]));
         if (!vecs[i].wr && vecs[i].chk_rd)
            check({vecs[i].name, ".data"}, rd, sb_q.pop_front());
      end

      // Full run: one clear cycle, ten steps with cnt 0..9, twelve busy cycles.
      do_write("start1", 32'h00, 64'h1, 1'b0);
      n_clr = 0; n_step = 0; n_busy = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (i == 0) check("busy_first", 64'(busy_o), 64'd1);
         if (sa_clear_o) n_clr++;
         if (busy_o) n_busy++;
         if (sa_step_o) begin
            check($sformatf("feed_cnt%0d", n_step), 64'(sa_cnt_o), 64'(n_step));
            check($sformatf("feed_addr%0d", n_step), 64'(op_addr_o), 64'(n_step));
            n_step++;
         end
      end
      check("clear_cycles", 64'(n_clr), 64'd1);
      check("step_cycles", 64'(n_step), 64'd10);
      check("busy_cycles", 64'(n_busy), 64'd12);
      @(posedge clk); #1;
      do_read("stat_done", 32'h00, 64'h2, 0);

      // Second run: busy errors, operand read serviced while stepping, start in DONE.
      do_write("start2", 32'h00, 64'h1, 1'b0);
      do_write("wr_b0_busy", 32'h80, 64'h99, 1'b1);
      do_read("stat_busy", 32'h00, 64'h1, 0);
      do_read("rd_a5_feed", 32'h54, 64'h11, 1);
      check("step_during_rd", 64'(sa_step_o), 64'd1);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (sa_step_o && sa_cnt_o == 8) found = 1'b1;
      end
      if (!found) begin
         n_checks++; n_errs++;
         $display("FAIL wait_cnt8: step with cnt 8 not seen, want it within 20 cycles");
      end
      @(posedge clk); #1;
      psel = 1'b1; pwrite = 1'b1; paddr = 32'h00; pwdata = 64'h1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      check("start_in_done.busy", 64'(busy_o), 64'd1);
      check("start_in_done.pready", 64'(pready_o), 64'd1);
      check("start_in_done.err", 64'(pslverr_o), 64'd1);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
      repeat (2) begin
         @(negedge clk);
         check("no_restart.busy", 64'(busy_o), 64'd0);
      end
      @(posedge clk); #1;
      do_read("stat_done2", 32'h00, 64'h2, 0);
      do_write("start3", 32'h00, 64'h1, 1'b0);
      do_read("stat_cleared", 32'h00, 64'h1, 0);

      // Reset asserted mid-FEED.
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (sa_step_o && sa_cnt_o == 4) found = 1'b1;
      end
      if (!found) begin
         n_checks++; n_errs++;
         $display("FAIL wait_cnt4: step with cnt 4 not seen, want it within 20 cycles");
      end
      rst_ni = 1'b0;
      #1 check_all_zero("rst_feed");
      @(posedge clk); #3 rst_ni = 1'b1;
      @(posedge clk); #1;
      do_read("stat_after_rst", 32'h00, 64'h0, 0);

      // Reset asserted during an operand-read wait state.
      psel = 1'b1; pwrite = 1'b0; paddr = 32'h54; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      check("rd_wait.pready", 64'(pready_o), 64'd0);
      #1 rst_ni = 1'b0;
      #1 check_all_zero("rst_wait");
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #3 rst_ni = 1'b1;
      @(posedge clk); #1;
      do_read("rd_a5_after_rst", 32'h54, 64'h11, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want completion earlier");
      $fatal(1);
   end

endmodule

// File: doc/matmul_sched.md
MATMUL_SCHED -- requirements
Module: matmul_sched

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the operand element width (8/16/32).
REQ-002 The block SHALL have parameter BUS_WIDTH, default 64, meaning the APB data width (16/32/64).
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the APB address width (16/24/32).
REQ-004 The block SHALL have parameter MAX_DIM, default 4, meaning the systolic array dimension; MATRIX_SIZE = MAX_DIM*MAX_DIM.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have these APB ports: psel_i, penable_i, pwrite_i  in  1 each; paddr_i  in  ADDR_WIDTH; pwdata_i  in  BUS_WIDTH; prdata_o  out  BUS_WIDTH; pready_o, pslverr_o  out  1 each.
REQ-007 The block SHALL have these operand-register ports: op_addr_o  out  ADDR_WIDTH  element index; op_wdata_o  out  DATA_WIDTH  write data; op_we_a_o, op_we_b_o  out  1 each  write enables; op_rdata_a_i, op_rdata_b_i  in  DATA_WIDTH  registered read data (1-cycle latency).
REQ-008 The block SHALL have these systolic-array ports: sa_clear_o  out  1  clear accumulators; sa_step_o  out  1  advance one wavefront; sa_cnt_o  out  $clog2(3*MAX_DIM)  wavefront index; busy_o  out  1  computation in progress.

Function
REQ-009 The address map SHALL be: paddr_i[7:6] selects region (0 ctrl/status, 1 operand A, 2 operand B, 3 illegal); paddr_i[5:2] selects the element index; other bits SHALL be ignored.
REQ-010 Region 0 SHALL hold a write-only start bit (pwdata_i[0]) and SHALL read status: bit0 busy, bit1 done (sticky), all other bits 0.
REQ-011 A write access (psel_i & penable_i & pwrite_i) SHALL complete with pready_o=1 in the same cycle (zero wait states).
REQ-012 An operand write SHALL drive op_we_a_o or op_we_b_o high for exactly that ACCESS cycle, with op_wdata_o = pwdata_i[DATA_WIDTH-1:0].
REQ-013 An operand read SHALL insert exactly one wait state (pready_o=0 in the first ACCESS cycle, 1 in the second), with prdata_o holding the zero-extended op_rdata_*_i in the second cycle.
REQ-014 Reads of region 0 SHALL complete with zero wait states.
REQ-015 pslverr_o SHALL be 1 only together with pready_o=1, for: any access to region 3; any write to regions 1/2 while busy; a start write while busy; errored accesses SHALL have no side effect.
REQ-016 The FSM SHALL have states IDLE, CLEAR, FEED, DONE.
REQ-017 IDLE -> CLEAR SHALL occur on an accepted start write; CLEAR SHALL last 1 cycle with sa_clear_o=1 and the done bit cleared.
REQ-018 FEED SHALL last exactly 3*MAX_DIM-2 cycles (10 at default), with sa_step_o=1 and sa_cnt_o counting 0..3*MAX_DIM-3.
REQ-019 DONE SHALL last 1 cycle, set the done bit, and return to IDLE.
REQ-020 busy_o SHALL be 1 in CLEAR, FEED and DONE and 0 in IDLE, giving 12 busy cycles at default from the cycle after the start write.
REQ-021 During FEED, op_addr_o SHALL be driven by the sequencer (sa_cnt_o mod MATRIX_SIZE) and APB reads of operand regions SHALL still be serviced, taking priority for op_addr_o in the read's first ACCESS cycle while stepping continues.
REQ-022 A start write with pwdata_i[0]=0 SHALL have no effect.

Reset
REQ-023 Asserting rst_ni=0 SHALL immediately force IDLE, clear done and the counter, and drive all outputs to 0 (pready_o, pslverr_o, busy_o, sa_*, op_we_*, prdata_o, op_addr_o, op_wdata_o), including when asserted mid-FEED or mid-wait-state.

Structure
REQ-024 A shared package matmul_pkg SHALL hold the FSM state enum, the region codes and the status bit positions.
REQ-025 The APB decode and wait-state logic SHALL be one sub-module, matmul_apb_if; the FSM and counter SHALL reside in matmul_sched.

Verification
REQ-026 Write A[5]=0x11 with no wait state, then read A[5] -> pready_o low for 1 cycle, then prdata_o=0x11 with pslverr_o=0.
REQ-027 Write start=1 -> sa_clear_o for 1 cycle, sa_step_o for 10 cycles with sa_cnt_o 0..9, busy_o high for 12 cycles, then status reads 0x2.
REQ-028 Write B[0] while busy -> pslverr_o=1 and op_we_b_o stays 0.
REQ-029 Access address 0xC0 -> pslverr_o=1 and pready_o=1 for both read and write.
REQ-030 Assert rst_ni low at FEED cycle 4 -> all outputs 0 at once; after release, status reads 0x0.
REQ-031 Write start=1 in DONE (busy) -> error; a second start from IDLE -> done bit cleared in CLEAR.
